// File: rtl/framebuffer_writer.sv
// Renders three 8-pixel letter slots into a back buffer one row per clock and
// commits the finished frame in a single edge so scan-out never sees a partial frame.
module framebuffer_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int X1   = 4,
  parameter int X2   = 16,
  parameter int X3   = 28
) (
  input  logic                 clock,
  input  logic                 reset_signal,
  input  logic                 frame_start,
  input  logic [7:0]           letter1,
  input  logic [7:0]           letter2,
  input  logic [7:0]           letter3,
  input  logic [4:0]           ypos1,
  input  logic [4:0]           ypos2,
  input  logic [4:0]           ypos3,
  output logic [COLS*ROWS-1:0] framebuffer,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int FBW = COLS * ROWS;
  localparam int AW  = $clog2(FBW);

  typedef enum logic [1:0] {IDLE, RENDER, COMMIT} state_t;

  state_t           state_q;
  logic [4:0]       row_q;
  logic [7:0]       let1_q, let2_q, let3_q;
  logic [4:0]       y1_q, y2_q, y3_q;
  logic [FBW-1:0]   back_q;
  logic [FBW-1:0]   fb_q;
  logic             busy_q;
  logic             done_q;

  logic [COLS-1:0]  row_pix;
  logic [AW-1:0]    row_base;

  // Letter bit 7 is the leftmost pixel, i.e. the lowest column index.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Row r only ever counts 0..ROWS-1, so ypos values of ROWS and above never match.
  always_comb begin
    row_pix = '0;
    if (y1_q == row_q) row_pix[X1 +: 8] = row_pix[X1 +: 8] | rev8(let1_q);
    if (y2_q == row_q) row_pix[X2 +: 8] = row_pix[X2 +: 8] | rev8(let2_q);
    if (y3_q == row_q) row_pix[X3 +: 8] = row_pix[X3 +: 8] | rev8(let3_q);
    row_base = AW'(int'(row_q) * COLS);
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= IDLE;
      row_q   <= '0;
      let1_q  <= '0;
      let2_q  <= '0;
      let3_q  <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      back_q  <= '0;
      fb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            let1_q  <= letter1;
            let2_q  <= letter2;
            let3_q  <= letter3;
            y1_q    <= ypos1;
            y2_q    <= ypos2;
            y3_q    <= ypos3;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RENDER;
          end
        end
        RENDER: begin
          back_q[row_base +: COLS] <= row_pix;
          if (row_q == 5'(ROWS - 1)) state_q <= COMMIT;
          else                       row_q   <= row_q + 5'd1;
        end
        COMMIT: begin
          fb_q    <= back_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign framebuffer = fb_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: hand-computed frames, timing of busy/frame_done,
// snapshot isolation, ignored requests and asynchronous reset.
module tb_framebuffer_writer;

  localparam int FBW = 1200;

  logic           clock = 1'b0;
  logic           reset_signal;
  logic           frame_start;
  logic [7:0]     letter1, letter2, letter3;
  logic [4:0]     ypos1, ypos2, ypos3;
  logic [FBW-1:0] framebuffer;
  logic           busy;
  logic           frame_done;

  int checks   = 0;
  int failures = 0;
  logic [FBW-1:0] last_exp;

  framebuffer_writer dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .frame_start  (frame_start),
    .letter1      (letter1),
    .letter2      (letter2),
    .letter3      (letter3),
    .ypos1        (ypos1),
    .ypos2        (ypos2),
    .ypos3        (ypos3),
    .framebuffer  (framebuffer),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [FBW-1:0] got, input logic [FBW-1:0] exp);
    int first;
    checks++;
    if (got !== exp) begin
      failures++;
      first = -1;
      for (int i = FBW - 1; i >= 0; i--) if (got[i] !== exp[i]) first = i;
      $display("FAIL %s got_lo=%0d exp_lo=%0d ones_got=%0d ones_exp=%0d first_diff_bit=%0d",
               tag, got[31:0], exp[31:0], $countones(got), $countones(exp), first);
    end
  endtask

  function automatic logic [FBW-1:0] bits4(input int a, input int b, input int c, input int d);
    logic [FBW-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  task automatic set_inputs(input logic [7:0] l1, input logic [4:0] y1,
                            input logic [7:0] l2, input logic [4:0] y2,
                            input logic [7:0] l3, input logic [4:0] y3);
    letter1 = l1; ypos1 = y1;
    letter2 = l2; ypos2 = y2;
    letter3 = l3; ypos3 = y3;
  endtask

  // Accept at E0, observe after each edge E0..E32; optionally mutate inputs at E5
  // and re-request at E10/E31 (ignored) and E32 (accepted, completes at E63).
  task automatic run_frame(input string tag, input logic [FBW-1:0] exp,
                           input bit mut, input bit extra);
    int done_cnt;
    bit busy_ok, hold_ok;
    done_cnt = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    @(negedge clock);
    frame_start = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      @(posedge clock);
      @(negedge clock);
      frame_start = 1'b0;
      if (extra && (e == 9 || e == 30 || e == 31)) frame_start = 1'b1;
      if (mut && e == 5) begin letter1 = 8'h01; ypos1 = 5'd6; end
      if (e <= 30) begin
        busy_ok = busy_ok & (busy === 1'b1);
        hold_ok = hold_ok & (framebuffer === last_exp);
        if (frame_done !== 1'b0) done_cnt++;
      end
      if (e == 31) begin
        chk({tag, "_fb"},   framebuffer, exp);
        chk({tag, "_done"}, FBW'(frame_done), FBW'(1));
        chk({tag, "_idle"}, FBW'(busy), FBW'(0));
        if (frame_done === 1'b1) done_cnt++;
      end
      if (e == 32) begin
        chk({tag, "_done_low"}, FBW'(frame_done), FBW'(0));
        chk({tag, "_busy32"},   FBW'(busy), FBW'(extra));
      end
    end
    chk({tag, "_busy_render"}, FBW'(busy_ok), FBW'(1));
    chk({tag, "_fb_hold"},     FBW'(hold_ok), FBW'(1));
    chk({tag, "_done_count"},  FBW'(done_cnt), FBW'(1));
    last_exp = exp;
    if (extra) begin
      for (int e = 33; e <= 63; e++) begin
        @(posedge clock);
        @(negedge clock);
        if (e == 62) chk({tag, "_2nd_early"}, FBW'(frame_done), FBW'(0));
      end
      chk({tag, "_2nd_done"}, FBW'(frame_done), FBW'(1));
      chk({tag, "_2nd_fb"},   framebuffer, exp);
      @(negedge clock);
    end
  endtask

  initial begin
    logic [FBW-1:0] e3;
    frame_start = 1'b0;
    set_inputs(8'h00, 5'd31, 8'h00, 5'd31, 8'h00, 5'd31);
    last_exp = '0;
    reset_signal = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_fb",   framebuffer, '0);
    chk("rst_busy", FBW'(busy), FBW'(0));
    chk("rst_done", FBW'(frame_done), FBW'(0));
    reset_signal = 1'b0;

    set_inputs(8'h00, 5'd31, 8'hA5, 5'd3, 8'h00, 5'd31);
    run_frame("single", bits4(136, 138, 141, 143), 1'b0, 1'b0);

    e3 = '0;
    for (int i = 4; i <= 11; i++) e3[i] = 1'b1;
    e3[416] = 1'b1; e3[423] = 1'b1; e3[1195] = 1'b1;
    set_inputs(8'hFF, 5'd0, 8'h81, 5'd10, 8'h01, 5'd29);
    run_frame("three", e3, 1'b0, 1'b0);

    // Mid-render asynchronous reset, observed between edges.
    @(negedge clock);
    frame_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    frame_start = 1'b0;
    repeat (14) @(posedge clock);
    #2 reset_signal = 1'b1;
    #1;
    chk("midrst_fb",   framebuffer, '0);
    chk("midrst_busy", FBW'(busy), FBW'(0));
    chk("midrst_done", FBW'(frame_done), FBW'(0));
    @(negedge clock);
    reset_signal = 1'b0;
    last_exp = '0;

    set_inputs(8'h80, 5'd5, 8'hFF, 5'd31, 8'hFF, 5'd31);
    run_frame("snapshot", bits4(204, -1, -1, -1), 1'b1, 1'b0);

    set_inputs(8'hFF, 5'd30, 8'hFF, 5'd31, 8'hFF, 5'd31);
    run_frame("offscreen", '0, 1'b0, 1'b0);

    set_inputs(8'h00, 5'd31, 8'hA5, 5'd3, 8'h00, 5'd31);
    run_frame("ignored", bits4(136, 138, 141, 143), 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Sequential renderer that builds the 1200-bit monochrome framebuffer consumed by the VGA scan-out block, writing one 40-pixel row per clock into a back buffer and committing it atomically. It sits between the three column state machines (letter/ypos sources) and the VGA block. It replaces combinational framebuffer generation, so the VGA reader never sees a half-drawn frame.

## Interface
Parameters:
- COLS, 40, pixels per row
- ROWS, 30, rows per frame (framebuffer width = COLS*ROWS = 1200)
- X1, 4, left column of letter slot 1
- X2, 16, left column of letter slot 2
- X3, 28, left column of letter slot 3 (each Xk+8 <= COLS)

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset_signal  in  1  asynchronous, active-high reset
- frame_start  in  1  render request, sampled each rising edge (driven from VGA vblank)
- letter1, letter2, letter3  in  8 each  8-bit glyph patterns for slots 1..3
- ypos1, ypos2, ypos3  in  5 each  row index of each slot
- framebuffer  out  1200  committed frame, bit index = row*COLS + col
- busy  out  1  high while a render is in progress
- frame_done  out  1  one-cycle pulse when a new frame is committed

## Operation
- States: IDLE, RENDER, COMMIT.
- IDLE: busy=0. On frame_start=1, snapshot all letterk/yposk into internal registers, row counter <= 0, go to RENDER.
- RENDER: each cycle compute row r from the snapshot and write it into back_buffer[r*COLS +: COLS]; row bits are zero except, for each slot k with ypos_k == r, bits at col Xk+(7-b) = letter_k[b] (letter bit 7 leftmost). Overlapping slots OR together. At r = ROWS-1 go to COMMIT, else r <= r+1.
- COMMIT: framebuffer <= back_buffer, frame_done <= 1 for this edge only, go to IDLE.
- yposk >= ROWS (30..31): slot k not drawn anywhere.
- Inputs changing during RENDER have no effect; only the snapshot is used.
- frame_start while busy or in COMMIT: ignored, not queued.
- framebuffer changes only on the COMMIT edge; never partially updated.
- Reset (any time, including mid-render): state IDLE, framebuffer = 0, back buffer = 0, row = 0, busy = 0, frame_done = 0, snapshot = 0.

## Timing
- Edge E0 samples frame_start=1: busy=1 after E0.
- Row r written at edge E(r+1), r = 0..29; state COMMIT after E30.
- Edge E31: framebuffer updated, frame_done=1 and busy=0 during cycle after E31; frame_done low after E32.
- Render latency: 31 edges from accept to visible framebuffer. Minimum request spacing: a frame_start sampled at E32 is accepted.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset_signal mid-RENDER -> framebuffer all zero, busy=0, frame_done=0 immediately (asynchronous); next frame_start renders normally.
- Single slot: letter2=8'hA5, ypos2=3, ypos1=ypos3=31, pulse frame_start -> after E31 exactly bits 136,138,141,143 set, frame_done one cycle, busy high for cycles E0..E30.
- Three slots: letter1=8'hFF ypos1=0, letter2=8'h81 ypos2=10, letter3=8'h01 ypos3=29 -> bits 4..11, 416, 423, 1195 set; all others 0.
- Snapshot: start with letter1=8'h80 ypos1=5, change to 8'h01 ypos1=6 at E5 -> committed frame has only bit 204 set.
- Ignored request: pulse frame_start at E10 and at E31 during busy -> only one frame_done; a pulse at E32 starts a second render (frame_done after E63).
- Off-screen and stability: ypos1=30, others 31 -> committed frame all zero; framebuffer holds previous frame unchanged during cycles E0..E30 of a new render.
